// File: rtl/dtbdm_filter_pipe.sv
// Three-stage decision-tree impulse-noise filter for one 3x3 window per cycle.
// Optional DTBDM_NOISE_STATS_EN adds iStatClr/ovNoiseCnt noisy-centre counting.
module dtbdm_filter_pipe #(
    parameter int PIX_W   = 8,
    parameter int LATENCY = 3
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iValid,
    output logic               oReady,
    input  logic               iBypassClean,
    input  logic [9*PIX_W-1:0] iv9xPWindow,
    input  logic [PIX_W-1:0]   ivMinij,
    input  logic [PIX_W-1:0]   ivMaxij,
    output logic [PIX_W-1:0]   ovPixelOut,
    output logic               oValid,
    input  logic               iReady,
    output logic               oCentreNoisy
`ifdef DTBDM_NOISE_STATS_EN
    ,
    input  logic               iStatClr,
    output logic [31:0]        ovNoiseCnt
`endif
);

    localparam int W = PIX_W;
    typedef logic [W-1:0] pix_t;

    generate
        if (LATENCY != 3) begin : g_latency_check
            $error("dtbdm_filter_pipe: LATENCY must be 3");
        end
    endgenerate

    function automatic logic is_noisy(input pix_t x, input pix_t mn, input pix_t mx);
        return (x >= mx) || (x <= mn);
    endfunction

    function automatic pix_t absdiff(input pix_t x, input pix_t y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic pix_t half_sum(input pix_t x, input pix_t y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[W:1];
    endfunction

    function automatic logic [W+1:0] ext(input pix_t x);
        return {2'b00, x};
    endfunction

    logic adv;
    assign adv    = ~oValid | iReady;
    assign oReady = adv;

    // flag vector layout: {fij, h, g, f, e, d}
    logic [5:0] in_nf;
    always_comb begin
        in_nf[0] = is_noisy(iv9xPWindow[6*W-1 -: W], ivMinij, ivMaxij);
        in_nf[1] = is_noisy(iv9xPWindow[4*W-1 -: W], ivMinij, ivMaxij);
        in_nf[2] = is_noisy(iv9xPWindow[3*W-1 -: W], ivMinij, ivMaxij);
        in_nf[3] = is_noisy(iv9xPWindow[2*W-1 -: W], ivMinij, ivMaxij);
        in_nf[4] = is_noisy(iv9xPWindow[W-1 -: W],   ivMinij, ivMaxij);
        in_nf[5] = is_noisy(iv9xPWindow[5*W-1 -: W], ivMinij, ivMaxij);
    end

    logic             v1, v2;
    logic [9*W-1:0]   s1_win, s2_win;
    logic [5:0]       s1_nf;
    logic             s1_byp, s2_byp, s2_nc, s2_fb;
    logic [2:0]       s2_idx;

    // Stage 2: direction costs and minimum-key selection
    pix_t a2, b2, c2, d2, e2, f2, g2, h2;
    assign a2 = s1_win[9*W-1 -: W];
    assign b2 = s1_win[8*W-1 -: W];
    assign c2 = s1_win[7*W-1 -: W];
    assign d2 = s1_win[6*W-1 -: W];
    assign e2 = s1_win[4*W-1 -: W];
    assign f2 = s1_win[3*W-1 -: W];
    assign g2 = s1_win[2*W-1 -: W];
    assign h2 = s1_win[W-1 -: W];

    logic [W:0] key [8];
    logic [W:0] best_key;
    logic [2:0] best_idx;
    logic       sel_fb;

    always_comb begin
        key[0] = {s1_nf[0] | s1_nf[1] | s1_nf[4], half_sum(absdiff(d2, h2), absdiff(a2, e2))};
        key[1] = {s1_nf[3] | s1_nf[4],            half_sum(absdiff(a2, g2), absdiff(b2, h2))};
        key[2] = {s1_nf[3],                       absdiff(b2, g2)};
        key[3] = {s1_nf[2] | s1_nf[3],            half_sum(absdiff(b2, f2), absdiff(c2, g2))};
        key[4] = {s1_nf[0] | s1_nf[1] | s1_nf[2], half_sum(absdiff(c2, d2), absdiff(e2, f2))};
        key[5] = {s1_nf[0] | s1_nf[1],            absdiff(d2, e2)};
        key[6] = {s1_nf[4],                       absdiff(a2, h2)};
        key[7] = {s1_nf[2],                       absdiff(c2, f2)};
        best_key = key[0];
        best_idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (key[k] < best_key) begin
                best_key = key[k];
                best_idx = 3'(k);
            end
        end
        sel_fb = best_key[W] | (&s1_nf[4:0]);
    end

    // Stage 3: directional estimate clamped to the middle pair of {b,d,e,g}
    pix_t a3, b3, c3, d3, x3, e3, f3, g3, h3;
    assign a3 = s2_win[9*W-1 -: W];
    assign b3 = s2_win[8*W-1 -: W];
    assign c3 = s2_win[7*W-1 -: W];
    assign d3 = s2_win[6*W-1 -: W];
    assign x3 = s2_win[5*W-1 -: W];
    assign e3 = s2_win[4*W-1 -: W];
    assign f3 = s2_win[3*W-1 -: W];
    assign g3 = s2_win[2*W-1 -: W];
    assign h3 = s2_win[W-1 -: W];

    localparam int unsigned CX_I [5] = '{0, 2, 0, 1, 1};
    localparam int unsigned CX_J [5] = '{1, 3, 2, 3, 2};

    logic [W+1:0] est_sum;
    logic         est_sh2;
    pix_t         est, tmp, clamped, out3;
    pix_t         srt [4];

    always_comb begin
        est_sum = '0;
        est_sh2 = 1'b1;
        if (s2_fb) begin
            est_sum = ext(a3) + {1'b0, b3, 1'b0} + ext(c3);
        end else begin
            case (s2_idx)
                3'd0: est_sum = ext(a3) + ext(d3) + ext(e3) + ext(h3);
                3'd1: est_sum = ext(a3) + ext(b3) + ext(g3) + ext(h3);
                3'd2: begin est_sum = ext(b3) + ext(g3); est_sh2 = 1'b0; end
                3'd3: est_sum = ext(b3) + ext(c3) + ext(f3) + ext(g3);
                3'd4: est_sum = ext(c3) + ext(d3) + ext(e3) + ext(f3);
                3'd5: begin est_sum = ext(d3) + ext(e3); est_sh2 = 1'b0; end
                3'd6: begin est_sum = ext(a3) + ext(h3); est_sh2 = 1'b0; end
                default: begin est_sum = ext(c3) + ext(f3); est_sh2 = 1'b0; end
            endcase
        end
        est = est_sh2 ? est_sum[W+1:2] : est_sum[W:1];

        srt[0] = b3;
        srt[1] = d3;
        srt[2] = e3;
        srt[3] = g3;
        tmp    = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (srt[CX_I[i]] > srt[CX_J[i]]) begin
                tmp          = srt[CX_I[i]];
                srt[CX_I[i]] = srt[CX_J[i]];
                srt[CX_J[i]] = tmp;
            end
        end

        if (est < srt[1])      clamped = srt[1];
        else if (est > srt[2]) clamped = srt[2];
        else                   clamped = est;

        out3 = (s2_byp && !s2_nc) ? x3 : clamped;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v1           <= 1'b0;
            v2           <= 1'b0;
            oValid       <= 1'b0;
            s1_win       <= '0;
            s1_nf        <= '0;
            s1_byp       <= 1'b0;
            s2_win       <= '0;
            s2_idx       <= '0;
            s2_fb        <= 1'b0;
            s2_nc        <= 1'b0;
            s2_byp       <= 1'b0;
            ovPixelOut   <= '0;
            oCentreNoisy <= 1'b0;
        end else if (adv) begin
            v1           <= iValid;
            s1_win       <= iv9xPWindow;
            s1_nf        <= in_nf;
            s1_byp       <= iBypassClean;
            v2           <= v1;
            s2_win       <= s1_win;
            s2_idx       <= best_idx;
            s2_fb        <= sel_fb;
            s2_nc        <= s1_nf[5];
            s2_byp       <= s1_byp;
            oValid       <= v2;
            ovPixelOut   <= out3;
            oCentreNoisy <= s2_nc;
        end
    end

`ifdef DTBDM_NOISE_STATS_EN
    always_ff @(posedge iClk) begin
        if (iRst || iStatClr) begin
            ovNoiseCnt <= '0;
        end else if (oValid && iReady && oCentreNoisy && (ovNoiseCnt != '1)) begin
            ovNoiseCnt <= ovNoiseCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtbdm_filter_pipe.sv
// Scoreboard bench for dtbdm_filter_pipe: driver pushes reference results, monitor pops on handshake.
module tb_dtbdm_filter_pipe;
    localparam int W = 8;
    localparam int PA = 0, PB = 1, PC = 2, PD = 3, PX = 4, PE = 5, PF = 6, PG = 7, PH = 8;

    logic           iClk = 1'b0;
    logic           iRst;
    logic           iValid;
    logic           oReady;
    logic           iBypassClean;
    logic [9*W-1:0] iv9xPWindow;
    logic [W-1:0]   ivMinij, ivMaxij;
    logic [W-1:0]   ovPixelOut;
    logic           oValid;
    logic           iReady;
    logic           oCentreNoisy;
`ifdef DTBDM_NOISE_STATS_EN
    logic           iStatClr;
    logic [31:0]    ovNoiseCnt;
    int             model_cnt = 0;
`endif

    dtbdm_filter_pipe #(.PIX_W(W), .LATENCY(3)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iBypassClean(iBypassClean), .iv9xPWindow(iv9xPWindow),
        .ivMinij(ivMinij), .ivMaxij(ivMaxij), .ovPixelOut(ovPixelOut),
        .oValid(oValid), .iReady(iReady), .oCentreNoisy(oCentreNoisy)
`ifdef DTBDM_NOISE_STATS_EN
        , .iStatClr(iStatClr), .ovNoiseCnt(ovNoiseCnt)
`endif
    );

    always #5 iClk = ~iClk;

    typedef struct { int pix; bit noisy; } exp_t;
    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int absd(input int x, input int y);
        return (x > y) ? x - y : y - x;
    endfunction

    // Reference: per-direction cost table, noisy directions ranked last, then clamp to median pair
    function automatic void model(input logic [9*W-1:0] w, input int mn, input int mx,
                                  input bit byp, output int pix, output bit nz);
        int p[9]; bit n[9]; int cost[8]; bit cn[8]; int best; int est; int s[4]; int t;
        for (int i = 0; i < 9; i++) begin
            p[i] = int'(w[(9-i)*W-1 -: W]);
            n[i] = (p[i] >= mx) || (p[i] <= mn);
        end
        cost[0] = (absd(p[PD], p[PH]) + absd(p[PA], p[PE])) / 2; cn[0] = n[PD] | n[PE] | n[PH];
        cost[1] = (absd(p[PA], p[PG]) + absd(p[PB], p[PH])) / 2; cn[1] = n[PG] | n[PH];
        cost[2] = absd(p[PB], p[PG]);                            cn[2] = n[PG];
        cost[3] = (absd(p[PB], p[PF]) + absd(p[PC], p[PG])) / 2; cn[3] = n[PF] | n[PG];
        cost[4] = (absd(p[PC], p[PD]) + absd(p[PE], p[PF])) / 2; cn[4] = n[PD] | n[PE] | n[PF];
        cost[5] = absd(p[PD], p[PE]);                            cn[5] = n[PD] | n[PE];
        cost[6] = absd(p[PA], p[PH]);                            cn[6] = n[PH];
        cost[7] = absd(p[PC], p[PF]);                            cn[7] = n[PF];
        best = 0;
        for (int k = 1; k < 8; k++)
            if ((cn[k] ? 100000 : 0) + cost[k] < (cn[best] ? 100000 : 0) + cost[best]) best = k;
        if (cn[best] || (n[PD] && n[PE] && n[PF] && n[PG] && n[PH]))
            est = (p[PA] + 2 * p[PB] + p[PC]) / 4;
        else begin
            case (best)
                0: est = (p[PA] + p[PD] + p[PE] + p[PH]) / 4;
                1: est = (p[PA] + p[PB] + p[PG] + p[PH]) / 4;
                2: est = (p[PB] + p[PG]) / 2;
                3: est = (p[PB] + p[PC] + p[PF] + p[PG]) / 4;
                4: est = (p[PC] + p[PD] + p[PE] + p[PF]) / 4;
                5: est = (p[PD] + p[PE]) / 2;
                6: est = (p[PA] + p[PH]) / 2;
                default: est = (p[PC] + p[PF]) / 2;
            endcase
        end
        s[0] = p[PB]; s[1] = p[PD]; s[2] = p[PE]; s[3] = p[PG];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        pix = (est < s[1]) ? s[1] : (est > s[2]) ? s[2] : est;
        if (byp && !n[PX]) pix = p[PX];
        nz = n[PX];
    endfunction

    function automatic logic [9*W-1:0] mkw(input int a, b, c, d, x, e, f, g, h);
        return {W'(a), W'(b), W'(c), W'(d), W'(x), W'(e), W'(f), W'(g), W'(h)};
    endfunction

    // Ready generator: 0 = always ready, 1 = random, 2 = low on stream cycles 4..7
    int rmode = 0;
    int rcyc  = 0;
    always @(posedge iClk) begin
        #1;
        case (rmode)
            1:       iReady = ($urandom % 10) < 7;
            2:       begin iReady = !(rcyc >= 4 && rcyc <= 7); rcyc++; end
            default: iReady = 1'b1;
        endcase
    end

    task automatic send(input logic [9*W-1:0] w, input int mn, input int mx, input bit byp,
                        input int ep, input bit en);
        bit accepted = 0;
        exp_t e;
        iValid = 1'b1; iv9xPWindow = w; ivMinij = W'(mn); ivMaxij = W'(mx); iBypassClean = byp;
        for (int t = 0; t < 200 && !accepted; t++) begin
            @(negedge iClk);
            if (oReady) begin
                e.pix = ep; e.noisy = en;
                sbq.push_back(e);
                accepted = 1;
            end
            @(posedge iClk); #1;
        end
        chk("send_accept", int'(accepted), 1);
    endtask

    task automatic sendm(input logic [9*W-1:0] w, input int mn, input int mx, input bit byp);
        int p; bit n;
        model(w, mn, mx, byp, p, n);
        send(w, mn, mx, byp, p, n);
    endtask

    task automatic idle(input int n);
        iValid = 1'b0;
        repeat (n) begin @(posedge iClk); #1; end
    endtask

    task automatic drain();
        iValid = 1'b0;
        for (int t = 0; t < 500 && sbq.size() != 0; t++) begin @(posedge iClk); #1; end
        chk("drain_left", sbq.size(), 0);
    endtask

    // Monitor: handshake decided at negedge, stable until next posedge
    bit       held_v = 0;
    int       held_p;
    bit       held_n;
    exp_t     mon_e;
    always @(negedge iClk) begin
        if (iRst) begin
            held_v = 0;
        end else begin
            chk("oready", int'(oReady), int'(!oValid || iReady));
            if (oValid) begin
                if (held_v) begin
                    chk("stall_pix", int'(ovPixelOut), held_p);
                    chk("stall_noisy", int'(oCentreNoisy), int'(held_n));
                end
                if (iReady) begin
                    held_v = 0;
                    if (sbq.size() == 0) chk("unexpected_out", 0, 1);
                    else begin
                        mon_e = sbq.pop_front();
                        chk("pix", int'(ovPixelOut), mon_e.pix);
                        chk("noisy", int'(oCentreNoisy), int'(mon_e.noisy));
`ifdef DTBDM_NOISE_STATS_EN
                        if (mon_e.noisy) model_cnt++;
`endif
                    end
                end else begin
                    held_v = 1; held_p = int'(ovPixelOut); held_n = oCentreNoisy;
                end
            end else begin
                held_v = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9*W-1:0] w;
        int mn, mx;
        iRst = 1'b1; iValid = 1'b1; iReady = 1'b1; iBypassClean = 1'b0;
        iv9xPWindow = mkw(1, 2, 3, 4, 5, 6, 7, 8, 9); ivMinij = 8'd0; ivMaxij = 8'd255;
`ifdef DTBDM_NOISE_STATS_EN
        iStatClr = 1'b0;
`endif
        repeat (2) @(posedge iClk);
        #1; iRst = 1'b0; iValid = 1'b0;
        @(negedge iClk);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_pix", int'(ovPixelOut), 0);
        chk("rst_noisy", int'(oCentreNoisy), 0);
        chk("rst_ready", int'(oReady), 1);
        @(posedge iClk); #1;

        // Directed windows with hand-derived results
        send({9{8'd100}}, 10, 200, 0, 100, 0);
        send(mkw(50, 50, 50, 100, 255, 100, 200, 200, 200), 0, 255, 0, 100, 1);
        send(mkw(40, 60, 80, 255, 128, 255, 255, 255, 255), 0, 255, 0, 255, 0);
        send(mkw(10, 20, 30, 10, 0, 40, 0, 30, 0), 100, 100, 0, 20, 1);
        send(mkw(20, 20, 20, 20, 77, 20, 20, 20, 20), 0, 255, 1, 77, 0);
        send(mkw(20, 20, 20, 20, 255, 20, 20, 20, 20), 0, 255, 1, 20, 1);
        drain();

        // Backpressure: six distinct windows streamed while iReady drops for four cycles
        rmode = 2; rcyc = 0;
        for (int i = 0; i < 6; i++) begin
            w = mkw(i * 30 + 1, $urandom % 256, $urandom % 256, $urandom % 256, $urandom % 256,
                    $urandom % 256, $urandom % 256, $urandom % 256, $urandom % 256);
            sendm(w, 20, 230, 0);
        end
        drain();
        rmode = 0;

        // Randomized traffic with random backpressure
        rmode = 1;
        for (int i = 0; i < 300; i++) begin
            mn = $urandom % 100;
            mx = ($urandom % 4 == 0) ? mn : mn + int'($urandom_range(0, 155));
            for (int j = 0; j < 9; j++)
                w[(9-j)*W-1 -: W] = ($urandom % 2) ? W'($urandom % 256)
                                  : W'((j % 3 == 0) ? mn : (j % 3 == 1) ? mx : 100 + ($urandom % 3));
            sendm(w, mn, mx, bit'($urandom % 2));
            if ($urandom % 4 == 0) idle(1);
        end
        drain();
        rmode = 0;

`ifdef DTBDM_NOISE_STATS_EN
        @(negedge iClk);
        chk("noise_cnt", int'(ovNoiseCnt), model_cnt);
        @(posedge iClk); #1; iStatClr = 1'b1;
        @(posedge iClk); #1; iStatClr = 1'b0; model_cnt = 0;
        for (int i = 0; i < 3; i++) send(mkw(20, 20, 20, 20, 255, 20, 20, 20, 20), 0, 255, 0, 20, 1);
        drain();
        @(negedge iClk);
        chk("noise_cnt3", int'(ovNoiseCnt), 3);
        @(posedge iClk); #1; iStatClr = 1'b1;
        @(posedge iClk); #1; iStatClr = 1'b0; model_cnt = 0;
        @(negedge iClk);
        chk("noise_cnt_clr", int'(ovNoiseCnt), 0);
        @(posedge iClk); #1;
`endif

        // Reset mid-stream: in-flight windows must vanish
        for (int i = 0; i < 3; i++) sendm(mkw(i, 9, 8, 7, 6, 5, 4, 3, 2), 0, 255, 0);
        iRst = 1'b1; iValid = 1'b0; sbq.delete();
`ifdef DTBDM_NOISE_STATS_EN
        model_cnt = 0;
`endif
        @(posedge iClk); #1; iRst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge iClk);
            chk("post_rst_valid", int'(oValid), 0);
            @(posedge iClk); #1;
        end
        sendm(mkw(5, 6, 7, 8, 9, 10, 11, 12, 13), 0, 255, 0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
